// File: rtl/exu_issue_pkg.sv
// Shared types for the IDU->EXU issue scheduler: FSM state and the 2-bit CSR index encoding.
package exu_issue_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SERIAL = 2'd2
  } issue_state_e;

  localparam int NCSR = 4;

  localparam logic [1:0] CSR_MSTATUS = 2'd0;
  localparam logic [1:0] CSR_MTVEC   = 2'd1;
  localparam logic [1:0] CSR_MEPC    = 2'd2;
  localparam logic [1:0] CSR_MCAUSE  = 2'd3;

endpackage

// File: rtl/exu_sb_counter.sv
// Saturating up/down scoreboard counter; underflow pulses when a lone decrement hits zero.
module exu_sb_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && !dec && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end else if (dec && !inc && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count     = count_reg;
  // Simultaneous inc/dec nets to zero change, so it is never an underflow.
  assign underflow = dec & ~inc & (count_reg == '0);

endmodule

// File: rtl/exu_issue_ctrl.sv
// Issue scheduler gating IDU->EXU with a GPR/CSR scoreboard and ecall/ebreak/CSR serialization.
// Optional stall counters are built when EXU_ISSUE_PERF_EN is defined.
module exu_issue_ctrl
  import exu_issue_pkg::*;
#(
  parameter int  NREG         = 32,
  parameter int  REG_AW       = 5,
  parameter int  MAX_INFLIGHT = 4,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idu_send_valid,
  input  logic [REG_AW-1:0] idu_rs1,
  input  logic [REG_AW-1:0] idu_rs2,
  input  logic              idu_rs1_used,
  input  logic              idu_rs2_used,
  input  logic [REG_AW-1:0] idu_rd,
  input  logic              idu_reg_write_en,
  input  logic [1:0]        idu_csr_rd,
  input  logic              idu_csr_read,
  input  logic              idu_csreg_write_en,
  input  logic              idu_serialize,
  output logic              idu_receive_ready,
  output logic              exu_receive_valid,
  input  logic              exu_send_ready,
  input  logic              wbu_retire_valid,
  input  logic [REG_AW-1:0] wbu_rd,
  input  logic              wbu_reg_write_en,
  input  logic [1:0]        wbu_csr_rd,
  input  logic              wbu_csreg_write_en,
  output logic              stall_raw,
  output logic [CNT_W-1:0]  inflight,
  output logic              sb_err
`ifdef EXU_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_raw_stall,
  output logic [31:0]       perf_full_stall,
  output logic [31:0]       perf_serial_stall
`endif
);

  logic [CNT_W-1:0] pend_gpr [NREG];
  logic [CNT_W-1:0] pend_csr [NCSR];
  logic [NREG-1:1]  gpr_uf;
  logic [NCSR-1:0]  csr_uf;
  logic             inflight_uf;
  issue_state_e     state_reg;
  logic             sb_err_reg;

  logic fire;
  logic hazard;
  logic full;
  logic issue_ok;
  logic retire_gpr;
  logic retire_csr;

  assign retire_gpr = wbu_retire_valid & wbu_reg_write_en;
  assign retire_csr = wbu_retire_valid & wbu_csreg_write_en;

  // x0 is hardwired: never tracked, always reads as free.
  assign pend_gpr[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_gpr
      exu_sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (fire & idu_reg_write_en & (idu_rd == REG_AW'(gi))),
        .dec       (retire_gpr & (wbu_rd == REG_AW'(gi))),
        .count     (pend_gpr[gi]),
        .underflow (gpr_uf[gi])
      );
    end
    for (gi = 0; gi < NCSR; gi++) begin : g_csr
      exu_sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (fire & idu_csreg_write_en & (idu_csr_rd == 2'(gi))),
        .dec       (retire_csr & (wbu_csr_rd == 2'(gi))),
        .count     (pend_csr[gi]),
        .underflow (csr_uf[gi])
      );
    end
  endgenerate

  exu_sb_counter #(.CNT_W(CNT_W)) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .inc       (fire),
    .dec       (wbu_retire_valid),
    .count     (inflight),
    .underflow (inflight_uf)
  );

  // Hazards look only at registered counters; a retiring writer frees its reader next cycle.
  assign hazard = (idu_rs1_used & (idu_rs1 != '0) & (pend_gpr[idu_rs1] != '0))
                | (idu_rs2_used & (idu_rs2 != '0) & (pend_gpr[idu_rs2] != '0))
                | (idu_csr_read & (pend_csr[idu_csr_rd] != '0));

  assign full = (inflight == CNT_W'(MAX_INFLIGHT));

  always_comb begin
    issue_ok = 1'b0;
    unique case (state_reg)
      RUN:     issue_ok = ~idu_serialize | (inflight == '0);
      DRAIN:   issue_ok = (inflight == '0);
      SERIAL:  issue_ok = 1'b0;
      default: issue_ok = 1'b0;
    endcase
  end

  assign exu_receive_valid = idu_send_valid & ~rst & ~hazard & ~full & issue_ok;
  assign fire              = exu_receive_valid & exu_send_ready;
  assign idu_receive_ready = fire;
  assign stall_raw         = idu_send_valid & hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (idu_send_valid && idu_serialize) begin
            if (fire) begin
              state_reg <= SERIAL;
            end else if (inflight != '0) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fire) begin
            state_reg <= SERIAL;
          end else if (!idu_send_valid) begin
            state_reg <= RUN;
          end
        end
        SERIAL: begin
          if (inflight == '0) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_reg <= 1'b0;
    end else if ((|gpr_uf) || (|csr_uf) || inflight_uf) begin
      sb_err_reg <= 1'b1;
    end
  end

  assign sb_err = sb_err_reg;

`ifdef EXU_ISSUE_PERF_EN
  logic [31:0] perf_raw_reg;
  logic [31:0] perf_full_reg;
  logic [31:0] perf_serial_reg;

  // Each blocked cycle is charged to exactly one cause: serial, then raw, then full.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_raw_reg    <= '0;
      perf_full_reg   <= '0;
      perf_serial_reg <= '0;
    end else if (idu_send_valid) begin
      if (!issue_ok) begin
        perf_serial_reg <= perf_serial_reg + 32'd1;
      end else if (hazard) begin
        perf_raw_reg <= perf_raw_reg + 32'd1;
      end else if (full) begin
        perf_full_reg <= perf_full_reg + 32'd1;
      end
    end
  end

  assign perf_raw_stall    = perf_raw_reg;
  assign perf_full_stall   = perf_full_reg;
  assign perf_serial_stall = perf_serial_reg;
`endif

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Self-checking bench for exu_issue_ctrl: directed scenarios plus randomized traffic vs a queue model.
module tb_exu_issue_ctrl;
  import exu_issue_pkg::*;

  localparam int MAXI = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       idu_send_valid = 1'b0;
  logic [4:0] idu_rs1 = '0;
  logic [4:0] idu_rs2 = '0;
  logic       idu_rs1_used = 1'b0;
  logic       idu_rs2_used = 1'b0;
  logic [4:0] idu_rd = '0;
  logic       idu_reg_write_en = 1'b0;
  logic [1:0] idu_csr_rd = '0;
  logic       idu_csr_read = 1'b0;
  logic       idu_csreg_write_en = 1'b0;
  logic       idu_serialize = 1'b0;
  logic       idu_receive_ready;
  logic       exu_receive_valid;
  logic       exu_send_ready = 1'b0;
  logic       wbu_retire_valid = 1'b0;
  logic [4:0] wbu_rd = '0;
  logic       wbu_reg_write_en = 1'b0;
  logic [1:0] wbu_csr_rd = '0;
  logic       wbu_csreg_write_en = 1'b0;
  logic       stall_raw;
  logic [2:0] inflight;
  logic       sb_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] rd;
    logic       we;
    logic [1:0] csr;
    logic       csrwe;
    logic       ser;
  } rec_t;

  exu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .idu_send_valid(idu_send_valid), .idu_rs1(idu_rs1), .idu_rs2(idu_rs2),
    .idu_rs1_used(idu_rs1_used), .idu_rs2_used(idu_rs2_used), .idu_rd(idu_rd),
    .idu_reg_write_en(idu_reg_write_en), .idu_csr_rd(idu_csr_rd), .idu_csr_read(idu_csr_read),
    .idu_csreg_write_en(idu_csreg_write_en), .idu_serialize(idu_serialize),
    .idu_receive_ready(idu_receive_ready), .exu_receive_valid(exu_receive_valid),
    .exu_send_ready(exu_send_ready), .wbu_retire_valid(wbu_retire_valid), .wbu_rd(wbu_rd),
    .wbu_reg_write_en(wbu_reg_write_en), .wbu_csr_rd(wbu_csr_rd),
    .wbu_csreg_write_en(wbu_csreg_write_en), .stall_raw(stall_raw),
    .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle();
    idu_send_valid = 1'b0; idu_rs1 = '0; idu_rs2 = '0; idu_rs1_used = 1'b0; idu_rs2_used = 1'b0;
    idu_rd = '0; idu_reg_write_en = 1'b0; idu_csr_rd = '0; idu_csr_read = 1'b0;
    idu_csreg_write_en = 1'b0; idu_serialize = 1'b0;
  endtask

  task automatic present(input logic [4:0] rs1, input logic rs1u, input logic [4:0] rd,
                         input logic we, input logic [1:0] csr, input logic csrrd,
                         input logic csrwe, input logic ser);
    idu_send_valid = 1'b1; idu_rs1 = rs1; idu_rs1_used = rs1u; idu_rs2 = '0; idu_rs2_used = 1'b0;
    idu_rd = rd; idu_reg_write_en = we; idu_csr_rd = csr; idu_csr_read = csrrd;
    idu_csreg_write_en = csrwe; idu_serialize = ser;
  endtask

  task automatic retire(input logic [4:0] rd, input logic we, input logic [1:0] csr, input logic csrwe);
    wbu_retire_valid = 1'b1; wbu_rd = rd; wbu_reg_write_en = we; wbu_csr_rd = csr;
    wbu_csreg_write_en = csrwe;
  endtask

  task automatic no_retire();
    wbu_retire_valid = 1'b0; wbu_rd = '0; wbu_reg_write_en = 1'b0; wbu_csr_rd = '0;
    wbu_csreg_write_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; exu_send_ready = 1'b1;
    present(5'd0, 1'b0, 5'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL reset_gate: exu_receive_valid=%0b expected 0", exu_receive_valid); end
    next_cycle(); next_cycle();
    rst = 1'b0; idle(); no_retire();
    #1;
    checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
    checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL reset_sb_err: got %0b expected 0", sb_err); end
    checks++; if (dut.state_reg !== RUN) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dut.state_reg, RUN); end
    checks++; if (stall_raw !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b expected 0", stall_raw); end
    $display("test_reset done");
    next_cycle();
  endtask

  task automatic test_raw();
    present(5'd0, 1'b0, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (exu_receive_valid !== 1'b1) begin failures++; $display("FAIL raw_first_issue: got %0b expected 1", exu_receive_valid); end
    next_cycle();
    present(5'd5, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (stall_raw !== 1'b1) begin failures++; $display("FAIL raw_stall: got %0b expected 1", stall_raw); end
      checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL raw_held: got %0b expected 0", exu_receive_valid); end
      checks++; if (inflight !== 3'd1) begin failures++; $display("FAIL raw_inflight: got %0d expected 1", inflight); end
      next_cycle();
    end
    retire(5'd5, 1'b1, 2'd0, 1'b0);
    #1;
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL raw_no_bypass: got %0b expected 0", exu_receive_valid); end
    next_cycle();
    no_retire();
    #1;
    checks++; if (exu_receive_valid !== 1'b1) begin failures++; $display("FAIL raw_release: got %0b expected 1", exu_receive_valid); end
    checks++; if (stall_raw !== 1'b0) begin failures++; $display("FAIL raw_release_stall: got %0b expected 0", stall_raw); end
    next_cycle();
    idle(); retire(5'd6, 1'b1, 2'd0, 1'b0);
    next_cycle();
    no_retire();
    #1;
    checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL raw_drained: got %0d expected 0", inflight); end
    checks++; if (dut.pend_gpr[6] !== 3'd0) begin failures++; $display("FAIL raw_pend6: got %0d expected 0", dut.pend_gpr[6]); end
    $display("test_raw done");
    next_cycle();
  endtask

  task automatic test_x0();
    int nz;
    present(5'd0, 1'b0, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (exu_receive_valid !== 1'b1) begin failures++; $display("FAIL x0_write_issue: got %0b expected 1", exu_receive_valid); end
    next_cycle();
    present(5'd0, 1'b1, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (exu_receive_valid !== 1'b1) begin failures++; $display("FAIL x0_read_issue: got %0b expected 1", exu_receive_valid); end
    checks++; if (stall_raw !== 1'b0) begin failures++; $display("FAIL x0_stall: got %0b expected 0", stall_raw); end
    next_cycle();
    idle();
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.pend_gpr[i] !== 3'd0) nz++;
    checks++; if (nz != 0) begin failures++; $display("FAIL x0_pend_zero: nonzero counters=%0d expected 0", nz); end
    checks++; if (inflight !== 3'd2) begin failures++; $display("FAIL x0_inflight: got %0d expected 2", inflight); end
    retire(5'd0, 1'b1, 2'd0, 1'b0);
    next_cycle(); next_cycle();
    no_retire();
    #1;
    checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL x0_drained: got %0d expected 0", inflight); end
    checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL x0_sb_err: got %0b expected 0", sb_err); end
    $display("test_x0 done");
    next_cycle();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      present(5'd0, 1'b0, 5'(10 + k), 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++; if (exu_receive_valid !== 1'b1) begin failures++; $display("FAIL full_fill_%0d: got %0b expected 1", k, exu_receive_valid); end
      next_cycle();
    end
    present(5'd1, 1'b1, 5'd14, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL full_held: got %0b expected 0", exu_receive_valid); end
    checks++; if (inflight !== 3'd4) begin failures++; $display("FAIL full_inflight: got %0d expected 4", inflight); end
    checks++; if (stall_raw !== 1'b0) begin failures++; $display("FAIL full_not_raw: got %0b expected 0", stall_raw); end
    next_cycle();
    retire(5'd10, 1'b1, 2'd0, 1'b0);
    #1;
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL full_no_bypass: got %0b expected 0", exu_receive_valid); end
    next_cycle();
    no_retire();
    #1;
    checks++; if (exu_receive_valid !== 1'b1) begin failures++; $display("FAIL full_release: got %0b expected 1", exu_receive_valid); end
    next_cycle();
    idle();
    for (int k = 11; k <= 14; k++) begin
      retire(5'(k), 1'b1, 2'd0, 1'b0);
      next_cycle();
    end
    no_retire();
    #1;
    checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL full_drained: got %0d expected 0", inflight); end
    checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL full_sb_err: got %0b expected 0", sb_err); end
    $display("test_full done");
    next_cycle();
  endtask

  task automatic test_serial();
    present(5'd0, 1'b0, 5'd20, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    present(5'd0, 1'b0, 5'd21, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    present(5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL serial_wait: got %0b expected 0", exu_receive_valid); end
    next_cycle();
    #1;
    checks++; if (dut.state_reg !== DRAIN) begin failures++; $display("FAIL serial_drain_state: got %0d expected %0d", dut.state_reg, DRAIN); end
    retire(5'd20, 1'b1, 2'd0, 1'b0);
    next_cycle();
    retire(5'd21, 1'b1, 2'd0, 1'b0);
    #1;
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL serial_still_drain: got %0b expected 0", exu_receive_valid); end
    next_cycle();
    no_retire();
    #1;
    checks++; if (exu_receive_valid !== 1'b1) begin failures++; $display("FAIL serial_issue: got %0b expected 1", exu_receive_valid); end
    checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL serial_issue_inflight: got %0d expected 0", inflight); end
    next_cycle();
    present(5'd0, 1'b0, 5'd22, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (dut.state_reg !== SERIAL) begin failures++; $display("FAIL serial_state: got %0d expected %0d", dut.state_reg, SERIAL); end
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL serial_block: got %0b expected 0", exu_receive_valid); end
    next_cycle();
    retire(5'd0, 1'b0, 2'd1, 1'b1);
    #1;
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL serial_block_retire: got %0b expected 0", exu_receive_valid); end
    next_cycle();
    no_retire();
    #1;
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL serial_exit_cycle: got %0b expected 0", exu_receive_valid); end
    next_cycle();
    #1;
    checks++; if (dut.state_reg !== RUN) begin failures++; $display("FAIL serial_back_run: got %0d expected %0d", dut.state_reg, RUN); end
    checks++; if (exu_receive_valid !== 1'b1) begin failures++; $display("FAIL serial_next_issue: got %0b expected 1", exu_receive_valid); end
    next_cycle();
    idle(); retire(5'd22, 1'b1, 2'd0, 1'b0);
    next_cycle();
    no_retire();
    #1;
    checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL serial_drained: got %0d expected 0", inflight); end
    checks++; if (dut.pend_csr[1] !== 3'd0) begin failures++; $display("FAIL serial_csr_clear: got %0d expected 0", dut.pend_csr[1]); end
    $display("test_serial done");
    next_cycle();
  endtask

  task automatic test_same_cycle_and_err();
    present(5'd0, 1'b0, 5'd7, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    retire(5'd7, 1'b1, 2'd0, 1'b0);
    #1;
    checks++; if (exu_receive_valid !== 1'b1) begin failures++; $display("FAIL same_issue: got %0b expected 1", exu_receive_valid); end
    next_cycle();
    idle(); no_retire();
    #1;
    checks++; if (dut.pend_gpr[7] !== 3'd1) begin failures++; $display("FAIL same_pend7: got %0d expected 1", dut.pend_gpr[7]); end
    checks++; if (inflight !== 3'd1) begin failures++; $display("FAIL same_inflight: got %0d expected 1", inflight); end
    checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL same_sb_err: got %0b expected 0", sb_err); end
    retire(5'd7, 1'b1, 2'd0, 1'b0);
    next_cycle();
    retire(5'd9, 1'b1, 2'd0, 1'b0);
    next_cycle();
    no_retire();
    #1;
    checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL sb_err_set: got %0b expected 1", sb_err); end
    checks++; if (dut.pend_gpr[9] !== 3'd0) begin failures++; $display("FAIL sb_err_pend9: got %0d expected 0", dut.pend_gpr[9]); end
    next_cycle(); next_cycle();
    #1;
    checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL sb_err_sticky: got %0b expected 1", sb_err); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL sb_err_clear: got %0b expected 0", sb_err); end
    $display("test_same_cycle_and_err done");
    next_cycle();
  endtask

  task automatic test_reset_midop();
    int nz;
    for (int k = 1; k <= 3; k++) begin
      present(5'd0, 1'b0, 5'(k), 1'b1, 2'(k), 1'b0, 1'b1, 1'b0);
      next_cycle();
    end
    present(5'd0, 1'b0, 5'd4, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (exu_receive_valid !== 1'b0) begin failures++; $display("FAIL midrst_gate: got %0b expected 0", exu_receive_valid); end
    next_cycle();
    rst = 1'b0; idle();
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.pend_gpr[i] !== 3'd0) nz++;
    for (int i = 0; i < 4; i++) if (dut.pend_csr[i] !== 3'd0) nz++;
    checks++; if (nz != 0) begin failures++; $display("FAIL midrst_counters: nonzero=%0d expected 0", nz); end
    checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL midrst_inflight: got %0d expected 0", inflight); end
    checks++; if (dut.state_reg !== RUN) begin failures++; $display("FAIL midrst_state: got %0d expected %0d", dut.state_reg, RUN); end
    $display("test_reset_midop done");
    next_cycle();
  endtask

  task automatic test_random();
    rec_t q[$];
    rec_t cur;
    logic       have, post_ser, hz, ser_in, permit, exp_v, do_ret, fire;
    logic [4:0] c_rs1, c_rs2;
    logic       c_rs1u, c_rs2u, c_csrrd;
    int         guard;
    have = 1'b0; post_ser = 1'b0;
    cur = '{rd: '0, we: 1'b0, csr: '0, csrwe: 1'b0, ser: 1'b0};
    c_rs1 = '0; c_rs2 = '0; c_rs1u = 1'b0; c_rs2u = 1'b0; c_csrrd = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!have && $urandom_range(3, 0) != 0) begin
        c_rs1 = 5'($urandom_range(7, 0)); c_rs1u = 1'($urandom_range(1, 0));
        c_rs2 = 5'($urandom_range(7, 0)); c_rs2u = 1'($urandom_range(1, 0));
        c_csrrd = ($urandom_range(3, 0) == 0);
        cur.rd = 5'($urandom_range(7, 0)); cur.we = 1'($urandom_range(1, 0));
        cur.csr = 2'($urandom_range(3, 0)); cur.csrwe = ($urandom_range(4, 0) == 0);
        cur.ser = ($urandom_range(9, 0) == 0);
        have = 1'b1;
      end
      idu_send_valid = have; idu_rs1 = c_rs1; idu_rs1_used = c_rs1u; idu_rs2 = c_rs2;
      idu_rs2_used = c_rs2u; idu_rd = cur.rd; idu_reg_write_en = cur.we; idu_csr_rd = cur.csr;
      idu_csr_read = c_csrrd; idu_csreg_write_en = cur.csrwe; idu_serialize = cur.ser;
      exu_send_ready = ($urandom_range(3, 0) != 0);
      do_ret = (q.size() > 0) && ($urandom_range(2, 0) == 0);
      if (do_ret) retire(q[0].rd, q[0].we, q[0].csr, q[0].csrwe);
      else no_retire();

      hz = 1'b0; ser_in = 1'b0;
      foreach (q[i]) begin
        if (q[i].we && c_rs1u && c_rs1 != 5'd0 && q[i].rd == c_rs1) hz = 1'b1;
        if (q[i].we && c_rs2u && c_rs2 != 5'd0 && q[i].rd == c_rs2) hz = 1'b1;
        if (q[i].csrwe && c_csrrd && q[i].csr == cur.csr) hz = 1'b1;
        if (q[i].ser) ser_in = 1'b1;
      end
      permit = !ser_in && !post_ser && (!cur.ser || q.size() == 0);
      exp_v = have && !hz && (q.size() < MAXI) && permit;
      fire = exp_v && exu_send_ready;
      #1;
      checks++; if (exu_receive_valid !== exp_v) begin failures++; $display("FAIL rnd_valid cyc=%0d: got %0b expected %0b", cyc, exu_receive_valid, exp_v); end
      checks++; if (idu_receive_ready !== fire) begin failures++; $display("FAIL rnd_ready cyc=%0d: got %0b expected %0b", cyc, idu_receive_ready, fire); end
      checks++; if (stall_raw !== (have && hz)) begin failures++; $display("FAIL rnd_stall cyc=%0d: got %0b expected %0b", cyc, stall_raw, have && hz); end
      checks++; if (inflight !== 3'(q.size())) begin failures++; $display("FAIL rnd_inflight cyc=%0d: got %0d expected %0d", cyc, inflight, q.size()); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL rnd_sb_err cyc=%0d: got %0b expected 0", cyc, sb_err); end

      post_ser = do_ret && q[0].ser;
      if (do_ret) void'(q.pop_front());
      if (fire) begin
        q.push_back(cur);
        have = 1'b0;
        $display("issue cyc=%0d rd=%0d we=%0b csr=%0d csrwe=%0b ser=%0b", cyc, cur.rd, cur.we, cur.csr, cur.csrwe, cur.ser);
      end
      next_cycle();
    end
    idle();
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      retire(q[0].rd, q[0].we, q[0].csr, q[0].csrwe);
      void'(q.pop_front());
      guard++;
      next_cycle();
    end
    no_retire();
    #1;
    checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL rnd_drained: got %0d expected 0", inflight); end
    checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL rnd_final_sb_err: got %0b expected 0", sb_err); end
    $display("test_random done");
    next_cycle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_raw();
    test_x0();
    test_full();
    test_serial();
    test_same_cycle_and_err();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
